// File: rtl/seq_udiv_restoring.sv
// ---------------------------------------------------------------------------
// seq_udiv_restoring
//
// Sequential unsigned restoring divider. It resolves one quotient bit per
// clock and sits behind valid/ready handshakes on both sides, so it drops
// into the same datapath as the multiplier wrappers.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     dividend/divisor presented
//   in_ready     block can accept an operation (high only in IDLE)
//   dividend     DW-bit unsigned dividend
//   divisor      VW-bit unsigned divisor
//   out_valid    result available (high only in DONE)
//   out_ready    consumer accepts result
//   quotient     DW-bit unsigned quotient (all ones on divide by zero)
//   remainder    VW-bit unsigned remainder (dividend low bits on divide by zero)
//   div_by_zero  result came from a zero divisor
//
// Timing: the accept edge plus DW iteration edges, so out_valid is seen
// DW+1 edges after acceptance counting the accept edge itself. A zero
// divisor skips the iterations and completes on the accept edge.
// ---------------------------------------------------------------------------
module seq_udiv_restoring #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [VW-1:0] prem;     // partial remainder, always < divisor
  logic [DW-1:0] quo_sr;   // dividend bits shift out the top, quotient bits in at the bottom
  logic [VW-1:0] dvs_q;

  logic [VW:0]   shifted;
  logic          fits;
  logic [VW-1:0] rem_nxt;
  logic [DW-1:0] quo_nxt;
  logic          last_iter;

  // One restoring step: returns {fits, new remainder}. The VW+1 bit
  // shifted value is compared against the divisor; the difference is
  // kept only when it is non-negative, otherwise the shifted value is
  // restored. Either way the result is below the divisor, so VW bits hold it.
  function automatic logic [VW:0] restore_step(input logic [VW:0]   sh,
                                               input logic [VW-1:0] d);
    logic ge;
    ge = (sh >= {1'b0, d});
    return {ge, ge ? VW'(sh - {1'b0, d}) : sh[VW-1:0]};
  endfunction

  assign shifted            = {prem, quo_sr[DW-1]};
  assign {fits, rem_nxt}    = restore_step(shifted, dvs_q);
  assign quo_nxt            = {quo_sr[DW-2:0], fits};
  assign last_iter          = (cnt == '0);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid)  state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (last_iter) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result registers.
  // Reset clears the results too so an aborted operation never leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      prem        <= '0;
      quo_sr      <= '0;
      dvs_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[VW-1:0];
              div_by_zero <= 1'b1;
            end else begin
              prem   <= '0;
              quo_sr <= dividend;
              dvs_q  <= divisor;
              cnt    <= CW'(DW - 1);
            end
          end
        end
        CALC: begin
          prem   <= rem_nxt;
          quo_sr <= quo_nxt;
          if (last_iter) begin
            quotient    <= quo_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;  // DONE: results hold until drained; IDLE keeps them too
      endcase
    end
  end

endmodule
